// File: rtl/cskipa_pkg.sv
// rtl/cskipa_pkg.sv - shared sizing, result FSM encoding and id-width helper
package cskipa_pkg;

  function automatic int cskipa_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CSKIPA_WIDTH    = 17;
  localparam int CSKIPA_NREQ     = 4;
  localparam int CSKIPA_ID_W     = cskipa_id_w(CSKIPA_NREQ);
  localparam int CSKIPA_SKIP_BLK = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/CSkipA_17bit.sv
// rtl/CSkipA_17bit.sv - combinational carry-skip adder, carry-in tied to zero
module CSkipA_17bit
  import cskipa_pkg::*;
#(
  parameter int WIDTH = CSKIPA_WIDTH,
  parameter int BLK   = CSKIPA_SKIP_BLK
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  always_comb begin
    logic v_c;
    logic v_blk_cin;
    logic v_blk_p;
    logic v_p;
    logic v_g;
    v_c       = 1'b0;
    v_blk_cin = 1'b0;
    v_blk_p   = 1'b0;
    v_p       = 1'b0;
    v_g       = 1'b0;
    o_sum     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % BLK == 0) begin
        v_blk_cin = v_c;
        v_blk_p   = 1'b1;
      end
      v_p      = i_a[i] ^ i_b[i];
      v_g      = i_a[i] & i_b[i];
      o_sum[i] = v_p ^ v_c;
      v_c      = v_g | (v_p & v_c);
      v_blk_p  = v_blk_p & v_p;
      // a fully-propagating block passes its incoming carry straight through
      if ((i % BLK == BLK - 1) || (i == WIDTH - 1))
        v_c = v_blk_p ? v_blk_cin : v_c;
    end
    o_cout = v_c;
  end

endmodule

// File: rtl/cskipa_arb_17bit.sv
// rtl/cskipa_arb_17bit.sv - round-robin shared carry-skip adder with one-entry result register
// Optional signed-overflow output o_res_ovf enabled by CSKIPA_ARB_OVF_EN.
module cskipa_arb_17bit
  import cskipa_pkg::*;
#(
  parameter  int WIDTH = CSKIPA_WIDTH,
  parameter  int NREQ  = CSKIPA_NREQ,
  localparam int ID_W  = cskipa_id_w(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [WIDTH-1:0]      o_res_sum,
  output logic                  o_res_cout,
`ifdef CSKIPA_ARB_OVF_EN
  output logic                  o_res_ovf,
`endif
  output logic [ID_W-1:0]       o_res_id
);

  res_state_t       r_state;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;

  logic             w_can_accept;
  logic             w_found;
  logic             w_xfer;
  logic [ID_W-1:0]  w_gnt;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // reset also kills the accept strobe combinationally
  assign w_can_accept = !i_rst && ((r_state == ST_EMPTY) || i_res_ready);

  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int off = 0; off < NREQ; off++) begin
      v_idx = int'(r_ptr) + off;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && i_req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'(v_idx);
      end
    end
  end

  assign w_xfer      = w_can_accept && w_found;
  assign o_req_ready = w_xfer ? (NREQ'(1) << w_gnt) : '0;
  assign w_ptr_nxt   = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + ID_W'(1);
  assign w_a         = i_req_a[w_gnt*WIDTH +: WIDTH];
  assign w_b         = i_req_b[w_gnt*WIDTH +: WIDTH];

  CSkipA_17bit #(.WIDTH(WIDTH)) u_adder (
    .i_a    (w_a),
    .i_b    (w_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_state <= ST_FULL;
      r_sum   <= w_sum;
      r_cout  <= w_cout;
      r_id    <= w_gnt;
      r_ptr   <= w_ptr_nxt;
    end else if (i_res_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign o_res_valid = (r_state == ST_FULL);
  assign o_res_sum   = r_sum;
  assign o_res_cout  = r_cout;
  assign o_res_id    = r_id;

`ifdef CSKIPA_ARB_OVF_EN
  logic r_ovf;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_ovf <= 1'b0;
    else if (w_xfer) r_ovf <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  end
  assign o_res_ovf = r_ovf;
`endif

endmodule

// File: doc/cskipa_arb_17bit.md
CSKIPA_ARB_17BIT -- requirements
Module: cskipa_arb_17bit

Interface
REQ-001 SHALL have parameter WIDTH, default 17, operand/sum width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters; ID_W = clog2(NREQ).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port o_req_ready  output  NREQ  per-requester accept strobe.
REQ-007 SHALL have port i_req_a  input  NREQ*WIDTH  packed operand A; requester k at [k*WIDTH +: WIDTH].
REQ-008 SHALL have port i_req_b  input  NREQ*WIDTH  packed operand B, same packing.
REQ-009 SHALL have port o_res_valid  output  1  result register holds data.
REQ-010 SHALL have port i_res_ready  input  1  downstream accepts result.
REQ-011 SHALL have ports o_res_sum (output, WIDTH, registered sum), o_res_cout (output, 1, registered carry-out) and o_res_id (output, ID_W, index of the source requester).

Function
REQ-012 SHALL share one carry-skip adder among NREQ requesters; a transfer occurs on requester k when i_req_valid[k] & o_req_ready[k].
REQ-013 SHALL use a two-state result FSM: EMPTY (o_res_valid=0) and FULL (o_res_valid=1).
REQ-014 SHALL define can_accept = EMPTY | (FULL & i_res_ready); o_req_ready SHALL be all-zero when can_accept=0.
REQ-015 SHALL assert at most one o_req_ready bit per cycle; that bit goes to the granted requester, which SHALL also have i_req_valid set.
REQ-016 SHALL grant round-robin: search starts at index ptr, wraps NREQ-1 -> 0, and takes the first valid requester.
REQ-017 SHALL update ptr to (granted index + 1) mod NREQ only on a transfer; ptr SHALL hold otherwise.
REQ-018 SHALL register {cout, sum} = A + B (WIDTH+1 bits, carry-in 0) and the granted index one cycle after the transfer; latency 1 cycle.
REQ-019 SHALL go EMPTY->FULL on a transfer, FULL->EMPTY on i_res_ready with no new transfer, and stay FULL on a simultaneous drain and transfer, loading the new result.
REQ-020 SHALL hold o_res_sum/o_res_cout/o_res_id stable while o_res_valid & !i_res_ready.
REQ-021 SHALL be a combinational function of registered state and inputs for o_req_ready, with no dependence on requester data.
REQ-022 SHALL make no grant and no state change, other than draining, when no i_req_valid bit is set.

Reset
REQ-023 SHALL, on i_rst assertion at any time including mid-transfer, immediately force EMPTY, o_res_valid=0, o_res_sum=0, o_res_cout=0, o_res_id=0, ptr=0 and o_req_ready=0.
REQ-024 SHALL discard any result held at reset; the first grant after reset release SHALL go to the lowest valid index.

Configuration
REQ-025 SHALL, when macro CSKIPA_ARB_OVF_EN is defined, add port o_res_ovf (output, 1), registered with the sum and equal to (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB]); reset value 0.
REQ-026 SHALL, when CSKIPA_ARB_OVF_EN is undefined, omit o_res_ovf, with all other behaviour identical.

Structure
REQ-027 SHALL take WIDTH, NREQ, ID_W and the FSM state encoding (EMPTY=0, FULL=1) from shared package cskipa_pkg.
REQ-028 SHALL instantiate exactly one sub-module, CSkipA_17bit, as the combinational adder; arbiter and FSM SHALL be inline.

Verification
REQ-029 SHALL verify a single request: req0 A=0x00001, B=0x1FFFF -> next cycle o_res_valid=1, sum=0x00000, cout=1, id=0.
REQ-030 SHALL verify fairness: all 4 valid continuously with i_res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-031 SHALL verify backpressure: result FULL, i_res_ready=0 for 5 cycles -> o_req_ready=0 and outputs stable; on ready=1 the next grant occurs the same cycle.
REQ-032 SHALL verify wrap: ptr=3 with only req1 and req2 valid -> req1 granted, ptr becomes 2.
REQ-033 SHALL verify reset mid-operation: i_rst asserted while FULL and a request is pending -> o_res_valid=0 immediately; after release the lowest valid index wins.
REQ-034 SHALL verify, with CSKIPA_ARB_OVF_EN defined, A=0x0FFFF, B=0x00001 -> sum=0x10000, o_res_ovf=1, cout=0.
